// File: rtl/trophy_scheduler_pkg.sv
// trophy_pkg: shared board constants and FSM state type for the trophy scheduler
package trophy_pkg;
  localparam int POS_W = 5;
  localparam int TMR_W = 8;
  localparam logic [POS_W-1:0] OFF_ROW = 5'd23;
  localparam logic [POS_W-1:0] OFF_COL = 5'd31;
  localparam logic [POS_W-1:0] ROW_MAX = 5'd15;
  localparam logic [POS_W-1:0] COL_MAX = 5'd23;
  typedef enum logic [2:0] {IDLE, SEL, REQ, CHECK, RUN} state_t;
endpackage

// File: rtl/trophy_scheduler_if.sv
// trophy_scheduler_if: req/vld handshake to the shared random candidate source
interface trophy_scheduler_if;
  import trophy_pkg::*;
  logic rand_req;
  logic rand_vld;
  logic [POS_W-1:0] rand_r;
  logic [POS_W-1:0] rand_c;
  modport master(output rand_req, input rand_vld, rand_r, rand_c);
  modport slave(input rand_req, output rand_vld, rand_r, rand_c);
endinterface

// File: rtl/trophy_respawn_timer.sv
// trophy_respawn_timer: per-slot tick countdown holding at zero
module trophy_respawn_timer import trophy_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [TMR_W-1:0] load_val,
  input  logic tick,
  input  logic en,
  output logic zero
);
  logic [TMR_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && en && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/trophy_scheduler.sv
// trophy_scheduler: places, collects, scores and respawns trophies from a shared random source
module trophy_scheduler import trophy_pkg::*; #(
  parameter int NUM = 3,
  parameter int RESPAWN_TICKS = 4,
  parameter int MAX_RETRY = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic game_start,
  input  logic game_end,
  input  logic tick,
  input  logic [POS_W-1:0] row,
  input  logic [POS_W-1:0] column,
  trophy_scheduler_if.master rnd,
  output logic [NUM-1:0] trophy_valid,
  output logic [POS_W*NUM-1:0] trophy_r_flat,
  output logic [POS_W*NUM-1:0] trophy_c_flat,
  output logic [7:0] score,
  output logic collect_pulse,
  output logic all_placed
);
  localparam int IW = NUM > 1 ? $clog2(NUM) : 1;
  localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY - 1);
  state_t state, state_n;
  logic [NUM-1:0][POS_W-1:0] tr_r, tr_c, tr_r_n, tr_c_n;
  logic [NUM-1:0] valid_n, pending, pending_n, tload, zero, hit, elig;
  logic [7:0] score_n, retry, retry_n;
  logic [IW-1:0] sel, sel_n, hit_idx, elig_idx;
  logic [POS_W-1:0] cand_r, cand_c, cand_r_n, cand_c_n;
  logic [TMR_W-1:0] tval;
  logic deferred, deferred_n, pulse_n, reject, req;
  assign rnd.rand_req = req;
  assign trophy_r_flat = tr_r;
  assign trophy_c_flat = tr_c;
  assign all_placed = &trophy_valid;
  assign tval = game_start ? '0 : TMR_W'(RESPAWN_TICKS);
  for (genvar t = 0; t < NUM; t++) begin : g_tmr
    trophy_respawn_timer u_tmr (
      .clk(clk), .rst(rst), .load(tload[t]), .load_val(tval),
      .tick(tick), .en(pending[t]), .zero(zero[t])
    );
  end
  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit = '0;
    elig = '0;
    hit_idx = '0;
    elig_idx = '0;
    reject = cand_r > ROW_MAX || cand_c > COL_MAX || (cand_r == row && cand_c == column);
    for (int i = NUM - 1; i >= 0; i--) begin
      hit[i] = trophy_valid[i] && tr_r[i] == row && tr_c[i] == column;
      elig[i] = pending[i] && zero[i];
      if (hit[i]) hit_idx = IW'(i);
      if (elig[i]) elig_idx = IW'(i);
      if (trophy_valid[i] && tr_r[i] == cand_r && tr_c[i] == cand_c) reject = 1'b1;
    end
  end
  always_comb begin
    state_n = state;
    valid_n = trophy_valid;
    tr_r_n = tr_r;
    tr_c_n = tr_c;
    score_n = score;
    pending_n = pending;
    retry_n = retry;
    sel_n = sel;
    cand_r_n = cand_r;
    cand_c_n = cand_c;
    deferred_n = deferred && !tick;
    pulse_n = 1'b0;
    tload = '0;
    if (game_end) begin
      state_n = IDLE;
      valid_n = '0;
      tr_r_n = {NUM{OFF_ROW}};
      tr_c_n = {NUM{OFF_COL}};
      deferred_n = 1'b0;
    end else if (game_start) begin
      state_n = SEL;
      valid_n = '0;
      tr_r_n = {NUM{OFF_ROW}};
      tr_c_n = {NUM{OFF_COL}};
      pending_n = '1;
      tload = '1;
      score_n = '0;
      retry_n = '0;
      deferred_n = 1'b0;
    end else begin
      if (state != IDLE && |hit) begin
        valid_n[hit_idx] = 1'b0;
        tr_r_n[hit_idx] = OFF_ROW;
        tr_c_n[hit_idx] = OFF_COL;
        pending_n[hit_idx] = 1'b1;
        tload[hit_idx] = 1'b1;
        score_n = score + {7'd0, score != 8'hff};
        pulse_n = 1'b1;
      end
      case (state)
        SEL: begin
          sel_n = elig_idx;
          state_n = |elig ? REQ : RUN;
        end
        REQ: if (rnd.rand_vld && req) begin
          cand_r_n = rnd.rand_r;
          cand_c_n = rnd.rand_c;
          state_n = CHECK;
        end
        CHECK: if (!reject) begin
          tr_r_n[sel] = cand_r;
          tr_c_n[sel] = cand_c;
          valid_n[sel] = 1'b1;
          pending_n[sel] = 1'b0;
          retry_n = '0;
          state_n = SEL;
        end else if (retry < RETRY_LIM) begin
          retry_n = retry + 1'b1;
          state_n = REQ;
        end else begin
          retry_n = '0;
          deferred_n = 1'b1;
          state_n = RUN;
        end
        // A deferred slot waits for the next tick instead of hammering the source.
        RUN: if (|elig && (tick || !deferred)) state_n = SEL;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk)
    if (rst) begin
      trophy_valid <= '0;
      tr_r <= {NUM{OFF_ROW}};
      tr_c <= {NUM{OFF_COL}};
      score <= '0;
      collect_pulse <= 1'b0;
      pending <= '0;
      retry <= '0;
      sel <= '0;
      cand_r <= '0;
      cand_c <= '0;
      deferred <= 1'b0;
      req <= 1'b0;
    end else begin
      trophy_valid <= valid_n;
      tr_r <= tr_r_n;
      tr_c <= tr_c_n;
      score <= score_n;
      collect_pulse <= pulse_n;
      pending <= pending_n;
      retry <= retry_n;
      sel <= sel_n;
      cand_r <= cand_r_n;
      cand_c <= cand_c_n;
      deferred <= deferred_n;
      req <= state_n == REQ;
    end
endmodule

// File: tb/tb_trophy_scheduler.sv
// tb_trophy_scheduler: directed checks of placement, rejection, collection, respawn and restart
module tb_trophy_scheduler;
  import trophy_pkg::*;
  logic clk = 1'b0;
  logic rst, game_start, game_end, tick;
  logic [4:0] row, column;
  logic [2:0] trophy_valid;
  logic [14:0] trophy_r_flat, trophy_c_flat;
  logic [7:0] score;
  logic collect_pulse, all_placed, take;
  logic [9:0] cq[$];
  int n_chk = 0;
  int n_fail = 0;

  trophy_scheduler_if rif();

  trophy_scheduler dut (
    .clk(clk), .rst(rst), .game_start(game_start), .game_end(game_end), .tick(tick),
    .row(row), .column(column), .rnd(rif.master),
    .trophy_valid(trophy_valid), .trophy_r_flat(trophy_r_flat), .trophy_c_flat(trophy_c_flat),
    .score(score), .collect_pulse(collect_pulse), .all_placed(all_placed)
  );

  always #5 clk = ~clk;

  // Random source model: presents the queue head, pops it once the DUT samples a handshake.
  always @(posedge clk) begin
    take = rif.rand_req && rif.rand_vld;
    #1;
    if (take && cq.size() != 0) void'(cq.pop_front());
    rif.rand_vld = cq.size() != 0;
    {rif.rand_r, rif.rand_c} = cq.size() != 0 ? cq[0] : 10'd0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(2);
  endtask

  task automatic wait_valid(input logic [2:0] exp, input int lim, input string tag);
    int n = 0;
    while (trophy_valid !== exp && n < lim) begin
      step(1);
      n++;
    end
    chk(tag, 32'(trophy_valid), 32'(exp));
  endtask

  task automatic push(input logic [4:0] r, input logic [4:0] c);
    cq.push_back({r, c});
  endtask

  initial begin
    rst = 1'b1;
    game_start = 1'b0;
    game_end = 1'b0;
    tick = 1'b0;
    row = 5'd9;
    column = 5'd9;
    step(3);
    chk("rst_valid", 32'(trophy_valid), 32'd0);
    chk("rst_r", 32'(trophy_r_flat), 32'({5'd23, 5'd23, 5'd23}));
    chk("rst_c", 32'(trophy_c_flat), 32'({5'd31, 5'd31, 5'd31}));
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_req", 32'(rif.rand_req), 32'd0);
    chk("rst_pulse", 32'(collect_pulse), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    push(5'd2, 5'd3);
    push(5'd4, 5'd5);
    push(5'd6, 5'd7);
    rst = 1'b0;
    step(2);
    // initial placement with a zero-wait source
    game_start = 1'b1;
    step(1);
    game_start = 1'b0;
    step(1);
    chk("k1_req", 32'(rif.rand_req), 32'd1);
    step(1);
    chk("k2_req", 32'(rif.rand_req), 32'd0);
    step(1);
    chk("k3_valid", 32'(trophy_valid), 32'd1);
    step(3);
    chk("k6_valid", 32'(trophy_valid), 32'd3);
    step(2);
    chk("k8_valid", 32'(trophy_valid), 32'd3);
    step(1);
    chk("k9_valid", 32'(trophy_valid), 32'd7);
    chk("all_placed", 32'(all_placed), 32'd1);
    chk("place_r", 32'(trophy_r_flat), 32'({5'd6, 5'd4, 5'd2}));
    chk("place_c", 32'(trophy_c_flat), 32'({5'd7, 5'd5, 5'd3}));
    step(2);
    // collect slot 1
    row = 5'd4;
    column = 5'd5;
    step(1);
    chk("col_pulse", 32'(collect_pulse), 32'd1);
    chk("col_score", 32'(score), 32'd1);
    chk("col_valid", 32'(trophy_valid), 32'd5);
    chk("col_r", 32'(trophy_r_flat), 32'({5'd6, 5'd23, 5'd2}));
    chk("col_c", 32'(trophy_c_flat), 32'({5'd7, 5'd31, 5'd3}));
    chk("col_all", 32'(all_placed), 32'd0);
    row = 5'd9;
    column = 5'd9;
    step(1);
    chk("col_pulse_end", 32'(collect_pulse), 32'd0);
    push(5'd16, 5'd3);
    push(5'd2, 5'd24);
    push(5'd9, 5'd9);
    push(5'd6, 5'd7);
    push(5'd4, 5'd5);
    repeat (3) do_tick();
    chk("resp_3tick_req", 32'(rif.rand_req), 32'd0);
    do_tick();
    chk("resp_4tick_req", 32'(rif.rand_req), 32'd1);
    // four rejects (row, col, player, occupied) then (4,5) accepted
    wait_valid(3'd7, 40, "rej_valid");
    chk("rej_r", 32'(trophy_r_flat), 32'({5'd6, 5'd4, 5'd2}));
    chk("rej_c", 32'(trophy_c_flat), 32'({5'd7, 5'd5, 5'd3}));
    chk("rej_retry", 32'(dut.retry), 32'd0);
    chk("rej_score", 32'(score), 32'd1);
    // collect slot 2 then exhaust retries
    row = 5'd6;
    column = 5'd7;
    step(1);
    chk("col2_score", 32'(score), 32'd2);
    row = 5'd9;
    column = 5'd9;
    repeat (8) push(5'd16, 5'd0);
    repeat (4) do_tick();
    step(20);
    chk("max_req", 32'(rif.rand_req), 32'd0);
    chk("max_state", 32'(dut.state), 32'(RUN));
    chk("max_valid", 32'(trophy_valid), 32'd3);
    chk("max_consumed", 32'(cq.size()), 32'd0);
    chk("max_retry", 32'(dut.retry), 32'd0);
    push(5'd10, 5'd10);
    step(5);
    chk("defer_state", 32'(dut.state), 32'(RUN));
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    chk("defer_req", 32'(rif.rand_req), 32'd1);
    step(2);
    chk("defer_valid", 32'(trophy_valid), 32'd7);
    chk("defer_r", 32'(trophy_r_flat), 32'({5'd10, 5'd4, 5'd2}));
    // game_end while holding REQ
    row = 5'd2;
    column = 5'd3;
    step(1);
    chk("col3_score", 32'(score), 32'd3);
    row = 5'd9;
    column = 5'd9;
    repeat (4) do_tick();
    step(3);
    chk("hold_req", 32'(rif.rand_req), 32'd1);
    game_end = 1'b1;
    step(1);
    game_end = 1'b0;
    chk("end_req", 32'(rif.rand_req), 32'd0);
    chk("end_valid", 32'(trophy_valid), 32'd0);
    chk("end_score", 32'(score), 32'd3);
    chk("end_r", 32'(trophy_r_flat), 32'({5'd23, 5'd23, 5'd23}));
    step(3);
    chk("end_state", 32'(dut.state), 32'(IDLE));
    // restart clears score
    push(5'd2, 5'd3);
    push(5'd4, 5'd5);
    push(5'd6, 5'd7);
    step(2);
    game_start = 1'b1;
    step(1);
    game_start = 1'b0;
    chk("restart_score", 32'(score), 32'd0);
    wait_valid(3'd7, 20, "restart_valid");
    // 255 collections of slot 0 reach saturation
    for (int i = 0; i < 255; i++) begin
      row = 5'd2;
      column = 5'd3;
      step(1);
      row = 5'd9;
      column = 5'd9;
      push(5'd2, 5'd3);
      repeat (4) do_tick();
      wait_valid(3'd7, 20, "sat_respawn");
    end
    chk("sat_score", 32'(score), 32'd255);
    row = 5'd2;
    column = 5'd3;
    step(1);
    chk("sat_pulse", 32'(collect_pulse), 32'd1);
    chk("sat_hold", 32'(score), 32'd255);
    chk("sat_valid", 32'(trophy_valid), 32'd6);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/trophy_scheduler.md
Name: trophy_scheduler

Overview:
Sequences trophy placement and respawn for the maze game. Draws candidate positions from a shared random source via a req/vld handshake and rejects off-board cells, the player's cell and occupied cells. Detects collection, scores it, and respawns each collected slot after a tick-based delay. Sits between the shared LFSR source and the VGA/trophy rendering path.

Parameters:
NUM, 3, number of trophy slots (1..8)
ROW_MAX, 15, largest legal trophy row
COL_MAX, 23, largest legal trophy column
RESPAWN_TICKS, 4, tick pulses from collection to respawn eligibility (1..255)
MAX_RETRY, 8, consecutive rejected candidates before the scheduler backs off to RUN

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
game_start  input  1  level; sampled high = start or restart a round
game_end  input  1  level; sampled high = stop the round
tick  input  1  one-cycle pulse; timebase for respawn timers
row  input  5  player row
column  input  5  player column
rand_req  output  1  request for a new random candidate
rand_vld  input  1  candidate valid; accepted only while rand_req=1
rand_r  input  5  candidate row
rand_c  input  5  candidate column
trophy_valid  output  NUM  per-slot "trophy on board"
trophy_r_flat  output  5*NUM  slot i row at [5i+4:5i]
trophy_c_flat  output  5*NUM  slot i column at [5i+4:5i]
score  output  8  collected count; saturates at 255
collect_pulse  output  1  one-cycle pulse per collection
all_placed  output  1  AND of trophy_valid

Behaviour:
- Reset (sync): state IDLE; trophy_valid=0; every row=23 and column=31 (off-board sentinel); score=0; rand_req=0; collect_pulse=0; pending=0; timers=0; retry=0.
- All outputs are registered. all_placed is derived from registered trophy_valid.
- States: IDLE, SEL, REQ, CHECK, RUN.
- Priority each edge: rst > game_end > game_start > normal operation.
- game_end in any state: go to IDLE, clear trophy_valid, restore sentinels, set rand_req=0. score holds its value.
- game_start in any state: clear trophy_valid, restore sentinels, set pending=all ones, timers=0, score=0, retry=0; go to SEL.
- SEL (1 cycle): choose the lowest-index slot with pending=1 and timer=0. If one exists, go to REQ and set rand_req=1. If none, go to RUN.
- REQ: hold rand_req=1. On the edge that samples rand_vld=1, capture rand_r/rand_c, clear rand_req, and go to CHECK. rand_vld sampled while rand_req=0 is ignored.
- CHECK (1 cycle): reject the candidate if r>ROW_MAX, c>COL_MAX, (r,c)==(row,column), or it matches any slot with trophy_valid=1 (registered values).
  - Accept: write the position into the slot, set its valid, clear its pending, set retry=0, go to SEL.
  - Reject with retry+1 < MAX_RETRY: increment retry, go to REQ.
  - Reject otherwise: set retry=0, go to RUN. The slot stays pending and is retried on the next tick.
- RUN: on a tick, or when any pending slot has timer=0 and was not just deferred, go to SEL. The simple form that meets this: go to SEL on each tick while any pending slot has timer=0.
- Collection runs every cycle in SEL, REQ, CHECK and RUN:
  - Trigger: valid slot i with position == (row,column).
  - Action: clear valid[i], write sentinels, set pending[i], set timer[i]=RESPAWN_TICKS, score=min(score+1,255), collect_pulse=1 for exactly one cycle.
  - Placement guarantees unique positions, so at most one slot is collected per cycle.
- Timers: decrement on tick while >0 and pending; hold at 0.
- Latency with a zero-wait source (rand_vld tied high):
  - Edge k samples game_start → SEL.
  - k+1 → REQ, rand_req=1.
  - k+2 → CHECK.
  - k+3 → trophy_valid[0]=1.
  - All NUM slots are placed by k+3*NUM.
- A candidate that matches a slot collected in the same CHECK cycle is still rejected. This is accepted as conservative.

Decomposition:
- Package trophy_pkg holds: OFF_ROW=5'd23, OFF_COL=5'd31, ROW_MAX, COL_MAX, the state enum (IDLE/SEL/REQ/CHECK/RUN), and a POS_W=5 constant.
- One sub-module, trophy_respawn_timer, instantiated NUM times.
  - Inputs: load, load value, tick, enable.
  - Output: zero flag.

Test Plan:
- Reset, rand_vld=1, rand_r/c sequence (2,3),(4,5),(6,7), game_start pulse → slots 0..2 hold those positions; trophy_valid=111 at k+3/k+6/k+9; all_placed=1.
- Candidate sequence (16,3),(2,24),(row,column),(2,3) with player at (9,9) → first three rejected; slot 0=(2,3); retry returns to 0.
- Candidate equal to a placed trophy → rejected; next distinct legal candidate accepted; no duplicate positions on board.
- Player steps onto slot 1 at (4,5) → collect_pulse one cycle; score 0→1; trophy_valid[1]=0 with (23,31); respawn request after exactly 4 ticks.
- MAX_RETRY=8 rejects in a row → state RUN with rand_req=0; next tick re-enters SEL for the same slot.
- game_end mid-REQ → IDLE, rand_req=0, trophy_valid=0, score held. Then game_start with score at 255 plus a collection → score stays 0 after the restart clear; saturation is checked separately with preload to 255 → stays 255.
